// File: rtl/wb_sram_bridge_pkg.sv
// wb_sram_bridge_pkg
//   Shared types and width helpers for the Wishbone-to-SRAM bridge.
//   t_wsb_state : bridge FSM state encoding
//   sel_width() : number of byte lanes for a given data width
//   off_width() : byte-offset bits in a Wishbone byte address

package wb_sram_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR      = 2'd1,
    RD_WAIT = 2'd2,
    RD_ACK  = 2'd3
  } t_wsb_state;

  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

  function automatic int off_width(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/wb_sram_bridge_lat.sv
// wb_sram_bridge_lat
//   Read-latency tracker: delays a one-cycle read strobe by RD_LAT cycles so
//   the output pulse lines up with the cycle in which SRAM read data is valid.
// Ports
//   clk_i  in  clock
//   rst_i  in  synchronous reset, active high (clears any in-flight strobe)
//   start  in  one-cycle read strobe
//   valid  out one-cycle pulse RD_LAT cycles after start

module wb_sram_bridge_lat #(
  parameter int RD_LAT = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start,
  output logic valid
);

  logic [RD_LAT-1:0] pipe;

  generate
    if (RD_LAT == 1) begin : g_single
      always_ff @(posedge clk_i) begin
        if (rst_i) pipe <= '0;
        else       pipe <= start;
      end
    end else begin : g_multi
      always_ff @(posedge clk_i) begin
        if (rst_i) pipe <= '0;
        else       pipe <= {pipe[RD_LAT-2:0], start};
      end
    end
  endgenerate

  assign valid = pipe[RD_LAT-1];

endmodule

// File: rtl/wb_sram_bridge.sv
// wb_sram_bridge
//   Pipelined Wishbone slave fronting one single-port synchronous SRAM.
//   One outstanding access; byte enables; configurable width/depth/latency.
//   Optional macro WB_SRAM_BRIDGE_ERR_EN: word addresses >= DEPTH are answered
//   with wb_err_o and never reach the SRAM. Without it wb_err_o stays 0 and
//   out-of-range addresses alias onto the SRAM address bits.
// Ports
//   clk_i, rst_i              clock, synchronous active-high reset
//   wb_cyc_i/stb_i/we_i       Wishbone cycle, strobe, write enable
//   wb_adr_i                  byte address (low byte-offset bits ignored)
//   wb_sel_i, wb_dat_i        byte selects, write data
//   wb_dat_o                  registered read data
//   wb_ack_o, wb_err_o        acknowledge, error
//   wb_stall_o                high whenever an access is in progress
//   sram_addr_o/data_o/sel_o  SRAM word address, write data, byte enables
//   sram_wr_o, sram_rd_o      one-cycle SRAM write / read strobes
//   sram_data_i               SRAM read data, valid RD_LAT cycles after sram_rd_o
//
//   state   | meaning
//   IDLE    | ready, accepts cyc & stb
//   WR      | SRAM write strobe and ack/err presented
//   RD_WAIT | read strobe issued, waiting RD_LAT cycles for data
//   RD_ACK  | read data on wb_dat_o, ack/err presented

module wb_sram_bridge
  import wb_sram_bridge_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 6,
  parameter  int RD_LAT     = 1,
  parameter  int DEPTH      = 64,
  localparam int SEL_W      = sel_width(DATA_WIDTH),
  localparam int OFF_W      = off_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH+OFF_W-1:0] wb_adr_i,
  input  logic [SEL_W-1:0]      wb_sel_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_data_o,
  output logic [SEL_W-1:0]      sram_sel_o,
  output logic                  sram_wr_o,
  output logic                  sram_rd_o,
  input  logic [DATA_WIDTH-1:0] sram_data_i
);

  t_wsb_state            state;
  logic [ADDR_WIDTH-1:0] adr_word;
  logic                  adr_bad;
  logic                  bad;       // current access is out of range
  logic                  abort;     // master dropped cyc during this access
  logic                  rd_pulse;  // read timing strobe, also for erroring reads
  logic                  lat_valid;

  assign adr_word = wb_adr_i[ADDR_WIDTH+OFF_W-1:OFF_W];

  generate
    if (OFF_W > 0) begin : g_off
      logic unused_low;
      assign unused_low = ^wb_adr_i[(OFF_W > 0 ? OFF_W-1 : 0):0];
    end
  endgenerate

`ifdef WB_SRAM_BRIDGE_ERR_EN
  assign adr_bad = (int'(adr_word) >= DEPTH);
`else
  localparam int unused_depth = DEPTH;
  assign adr_bad = 1'b0;
`endif

  assign wb_stall_o = (state != IDLE);

  wb_sram_bridge_lat #(
    .RD_LAT (RD_LAT)
  ) u_lat (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start  (rd_pulse),
    .valid  (lat_valid)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      bad         <= 1'b0;
      abort       <= 1'b0;
      rd_pulse    <= 1'b0;
      wb_dat_o    <= '0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      sram_addr_o <= '0;
      sram_data_o <= '0;
      sram_sel_o  <= '0;
      sram_wr_o   <= 1'b0;
      sram_rd_o   <= 1'b0;
    end else begin
      sram_wr_o <= 1'b0;
      sram_rd_o <= 1'b0;
      rd_pulse  <= 1'b0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;

      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            // Direction is carried by the next state, so we is not kept.
            sram_addr_o <= adr_word;
            sram_sel_o  <= wb_sel_i;
            sram_data_o <= wb_dat_i;
            bad         <= adr_bad;
            abort       <= 1'b0;
            if (wb_we_i) begin
              state     <= WR;
              sram_wr_o <= ~adr_bad;
              wb_ack_o  <= ~adr_bad;
              wb_err_o  <= adr_bad;
            end else begin
              state     <= RD_WAIT;
              sram_rd_o <= ~adr_bad;
              rd_pulse  <= 1'b1;
            end
          end
        end

        WR: state <= IDLE;

        RD_WAIT: begin
          if (!wb_cyc_i) abort <= 1'b1;
          if (lat_valid) begin
            if (!bad) wb_dat_o <= sram_data_i;
            // The read completes on the SRAM side regardless; only the
            // bus response is withheld once the master has gone away.
            wb_ack_o <= wb_cyc_i & ~abort & ~bad;
            wb_err_o <= wb_cyc_i & ~abort & bad;
            state    <= RD_ACK;
          end
        end

        RD_ACK: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_sram_bridge.sv
module tb_wb_sram_bridge;

  localparam int DW     = 32;
  localparam int AW     = 6;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 48;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we  = 1'b0;
  logic [7:0]  adr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_w = '0;
  logic [31:0] dat_r;
  logic        ack, err, stall;
  logic [5:0]  s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_sel;
  logic        s_wr, s_rd;
  logic [31:0] s_rdata;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  wb_sram_bridge #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RD_LAT     (RD_LAT),
    .DEPTH      (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .wb_cyc_i    (cyc),
    .wb_stb_i    (stb),
    .wb_we_i     (we),
    .wb_adr_i    (adr),
    .wb_sel_i    (sel),
    .wb_dat_i    (dat_w),
    .wb_dat_o    (dat_r),
    .wb_ack_o    (ack),
    .wb_err_o    (err),
    .wb_stall_o  (stall),
    .sram_addr_o (s_addr),
    .sram_data_o (s_wdata),
    .sram_sel_o  (s_sel),
    .sram_wr_o   (s_wr),
    .sram_rd_o   (s_rd),
    .sram_data_i (s_rdata)
  );

  // Byte-lane SRAM model, read data valid for exactly one cycle RD_LAT (=2)
  // cycles after the read strobe; garbage otherwise.
  logic [31:0] mem [64];
  logic [31:0] q1, q2;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (s_wr) begin
      for (int b = 0; b < 4; b++)
        if (s_sel[b]) mem[s_addr][8*b +: 8] <= s_wdata[8*b +: 8];
    end
    q1 <= s_rd ? mem[s_addr] : 32'hBAD0_BAD0;
    q2 <= q1;
  end
  assign s_rdata = q2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wb_write(input string tag, input logic [7:0] a, input logic [3:0] s,
                          input logic [31:0] d);
    chk({tag, ".idle_stall"}, 64'(stall), 64'(0));
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; sel = s; dat_w = d;
    @(negedge clk);
    chk({tag, ".wr"},    64'(s_wr),    64'(1));
    chk({tag, ".ack"},   64'(ack),     64'(1));
    chk({tag, ".stall"}, 64'(stall),   64'(1));
    chk({tag, ".addr"},  64'(s_addr),  64'(a[7:2]));
    chk({tag, ".sel"},   64'(s_sel),   64'(s));
    chk({tag, ".wdata"}, 64'(s_wdata), 64'(d));
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk({tag, ".wr_end"},    64'(s_wr),  64'(0));
    chk({tag, ".ack_end"},   64'(ack),   64'(0));
    chk({tag, ".stall_end"}, 64'(stall), 64'(0));
    cyc = 1'b0;
  endtask

  task automatic wb_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a; sel = 4'hF;
    @(negedge clk);
    chk({tag, ".rd"},    64'(s_rd),   64'(1));
    chk({tag, ".stall"}, 64'(stall),  64'(1));
    chk({tag, ".addr"},  64'(s_addr), 64'(a[7:2]));
    stb = 1'b0;
    for (int k = 2; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      chk({tag, ".rd_once"},   64'(s_rd), 64'(0));
      chk({tag, ".ack_early"}, 64'(ack),  64'(0));
    end
    @(negedge clk);
    chk({tag, ".ack"},  64'(ack),   64'(1));
    chk({tag, ".err"},  64'(err),   64'(0));
    chk({tag, ".data"}, 64'(dat_r), 64'(exp));
    @(negedge clk);
    chk({tag, ".ack_end"},   64'(ack),   64'(0));
    chk({tag, ".stall_end"}, 64'(stall), 64'(0));
    chk({tag, ".data_hold"}, 64'(dat_r), 64'(exp));
    cyc = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nwr, nack;

    repeat (3) @(negedge clk);
    chk("rst.ack",   64'(ack),     64'(0));
    chk("rst.err",   64'(err),     64'(0));
    chk("rst.stall", 64'(stall),   64'(0));
    chk("rst.wr",    64'(s_wr),    64'(0));
    chk("rst.rd",    64'(s_rd),    64'(0));
    chk("rst.dat",   64'(dat_r),   64'(0));
    chk("rst.addr",  64'(s_addr),  64'(0));
    chk("rst.sel",   64'(s_sel),   64'(0));
    chk("rst.wdata", 64'(s_wdata), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // 1/2: full-word write then read back
    wb_write("t1", 8'h10, 4'hF, 32'hDEAD_BEEF);
    wb_read ("t2", 8'h10, 32'hDEAD_BEEF);

    // 3: partial byte-lane write
    wb_write("t3a", 8'h20, 4'hF, 32'hAAAA_BBBB);
    wb_write("t3b", 8'h20, 4'h5, 32'h1122_3344);
    wb_read ("t3c", 8'h20, 32'hAA22_BB44);

    // 4: strobe held across three queued writes
    nwr = 0; nack = 0;
    cyc = 1'b1; we = 1'b1; sel = 4'hF;
    for (int k = 0; k < 8; k++) begin
      if (k < 6) chk("t4.stall_pat", 64'(stall), 64'(k % 2));
      if (s_wr) nwr++;
      if (ack)  nack++;
      case (k)
        0: begin stb = 1'b1; adr = 8'h04; dat_w = 32'h1111_0001; end
        2: begin adr = 8'h08; dat_w = 32'h1111_0002; end
        4: begin adr = 8'h0C; dat_w = 32'h1111_0003; end
        5: begin stb = 1'b0; we = 1'b0; end
        default: ;
      endcase
      @(negedge clk);
    end
    cyc = 1'b0;
    chk("t4.wr_count",  64'(nwr),  64'(3));
    chk("t4.ack_count", 64'(nack), 64'(3));
    wb_read("t4.rb1", 8'h04, 32'h1111_0001);
    wb_read("t4.rb3", 8'h0C, 32'h1111_0003);

    // 5a: master drops cyc during read wait
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h10;
    @(negedge clk);
    chk("t5a.rd", 64'(s_rd), 64'(1));
    stb = 1'b0;
    @(negedge clk);
    cyc = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5a.no_ack", 64'(ack), 64'(0));
      chk("t5a.no_err", 64'(err), 64'(0));
    end
    chk("t5a.stall", 64'(stall), 64'(0));

    // 5b: reset in the middle of a read wait
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'h10;
    @(negedge clk);
    chk("t5b.rd", 64'(s_rd), 64'(1));
    stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5b.stall", 64'(stall), 64'(0));
    chk("t5b.rd0",   64'(s_rd),  64'(0));
    chk("t5b.ack0",  64'(ack),   64'(0));
    chk("t5b.dat0",  64'(dat_r), 64'(0));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5b.no_ack", 64'(ack), 64'(0));
    end
    cyc = 1'b0;
    wb_read("t5b.recover", 8'h10, 32'hC0DE_0004);

    // 6: word 50 is beyond DEPTH=48
`ifdef WB_SRAM_BRIDGE_ERR_EN
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 8'hC8;
    @(negedge clk);
    chk("t6.no_rd", 64'(s_rd),  64'(0));
    chk("t6.stall", 64'(stall), 64'(1));
    stb = 1'b0;
    for (int k = 2; k <= RD_LAT + 1; k++) begin
      @(negedge clk);
      chk("t6.err_early", 64'(err), 64'(0));
      chk("t6.no_rd2",    64'(s_rd), 64'(0));
    end
    @(negedge clk);
    chk("t6.err",  64'(err),   64'(1));
    chk("t6.ack",  64'(ack),   64'(0));
    chk("t6.dat",  64'(dat_r), 64'(32'hC0DE_0004));
    @(negedge clk);
    chk("t6.err_end",   64'(err),   64'(0));
    chk("t6.stall_end", 64'(stall), 64'(0));
    stb = 1'b1; we = 1'b1; adr = 8'hC8; dat_w = 32'h5555_5555;
    @(negedge clk);
    chk("t6w.no_wr", 64'(s_wr), 64'(0));
    chk("t6w.err",   64'(err),  64'(1));
    chk("t6w.ack",   64'(ack),  64'(0));
    stb = 1'b0; we = 1'b0;
    @(negedge clk);
    chk("t6w.err_end", 64'(err), 64'(0));
    cyc = 1'b0;
`else
    wb_read("t6", 8'hC8, 32'hC0DE_0032);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
